// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage MIPS pipeline:
//   - writeback select encodings (MEMTOREG_*)
//   - architectural register numbers ($0, $sp, $ra)
//   - register address and data word typedefs
// ----------------------------------------------------------------------------
package pipe_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;
    localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_SP   = 5'd29;
    localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_core.sv
// ----------------------------------------------------------------------------
// regfile_core
// Architectural register storage: NREG x DATA_W array, one synchronous write
// port, two combinational read ports. Register 0 is hard-wired to zero.
// Synchronous active-low reset clears every register except $sp, which is
// loaded with SP_RST. Reset wins over a write in the same cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset
//   i_we       in   write enable
//   i_waddr    in   write address
//   i_wdata    in   write data
//   i_raddr1   in   read port 1 address
//   i_raddr2   in   read port 2 address
//   o_rdata1   out  read port 1 data (combinational)
//   o_rdata2   out  read port 2 data (combinational)
// ----------------------------------------------------------------------------
module regfile_core
    import pipe_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter int                NREG   = 32,
    parameter logic [DATA_W-1:0] SP_RST = 32'h0000_07FC,
    localparam int               AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr1,
    input  logic [AW-1:0]     i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);

    logic [DATA_W-1:0] r_regs [NREG];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= (i == int'(REG_SP)) ? SP_RST : '0;
            end
        end else if (i_we && (i_waddr != AW'(REG_ZERO))) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // $0 is forced to zero on the read side as well, so it never depends on
    // what the array slot holds.
    assign o_rdata1 = (i_raddr1 == AW'(REG_ZERO)) ? '0 : r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == AW'(REG_ZERO)) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/wb_regfile.sv
// ----------------------------------------------------------------------------
// wb_regfile
// Writeback stage plus architectural register file. Selects the writeback
// value from the MEM/WB outputs, commits it to regfile_core and exports the
// in-flight writeback (data/enable/address) combinationally for forwarding.
//
// Optional build macro: WB_BYPASS_EN
//   defined   - a read whose address matches an active writeback returns the
//               writeback value in the same cycle (WB->ID bypass).
//   undefined - read ports return stored contents only.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-low reset
//   memdata_i   in   load data
//   alures_i    in   ALU result
//   pc4_i       in   PC+4 (link value for jal/jalr)
//   memtoreg_i  in   writeback select (00 ALU, 01 Mem, 10 PC+4, 11 ALU)
//   regwr_i     in   writeback enable
//   rf_i        in   destination register
//   rs_addr_i   in   read port 1 address
//   rt_addr_i   in   read port 2 address
//   rs_data_o   out  read port 1 data
//   rt_data_o   out  read port 2 data
//   wb_data_o   out  selected writeback value
//   wb_en_o     out  regwr_i and rf_i != 0
//   wb_addr_o   out  destination register (rf_i)
// ----------------------------------------------------------------------------
module wb_regfile
    import pipe_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter int                NREG   = 32,
    parameter logic [DATA_W-1:0] SP_RST = 32'h0000_07FC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] memdata_i,
    input  logic [DATA_W-1:0] alures_i,
    input  logic [DATA_W-1:0] pc4_i,
    input  logic [1:0]        memtoreg_i,
    input  logic              regwr_i,
    input  reg_addr_t         rf_i,
    input  reg_addr_t         rs_addr_i,
    input  reg_addr_t         rt_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_en_o,
    output reg_addr_t         wb_addr_o
);

    logic [DATA_W-1:0] w_wb_data;
    logic              w_wb_en;
    logic [DATA_W-1:0] w_rs_core;
    logic [DATA_W-1:0] w_rt_core;

    always_comb begin
        w_wb_data = alures_i;
        case (memtoreg_i)
            MEMTOREG_MEM: w_wb_data = memdata_i;
            MEMTOREG_PC4: w_wb_data = pc4_i;
            default:      w_wb_data = alures_i;
        endcase
    end

    // Writes to $0 are suppressed here so forwarding never sees them either.
    assign w_wb_en = regwr_i && (rf_i != REG_ZERO);

    regfile_core #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .SP_RST (SP_RST)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .i_we     (w_wb_en),
        .i_waddr  (rf_i),
        .i_wdata  (w_wb_data),
        .i_raddr1 (rs_addr_i),
        .i_raddr2 (rt_addr_i),
        .o_rdata1 (w_rs_core),
        .o_rdata2 (w_rt_core)
    );

`ifdef WB_BYPASS_EN
    // w_wb_en already excludes $0, so a $0 read can never pick up the bypass.
    always_comb begin
        rs_data_o = w_rs_core;
        rt_data_o = w_rt_core;
        if (w_wb_en && (rs_addr_i == rf_i)) rs_data_o = w_wb_data;
        if (w_wb_en && (rt_addr_i == rf_i)) rt_data_o = w_wb_data;
    end
`else
    assign rs_data_o = w_rs_core;
    assign rt_data_o = w_rt_core;
`endif

    assign wb_data_o = w_wb_data;
    assign wb_en_o   = w_wb_en;
    assign wb_addr_o = rf_i;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] memdata_i, alures_i, pc4_i;
    logic [1:0]  memtoreg_i;
    logic        regwr_i;
    logic [4:0]  rf_i, rs_addr_i, rt_addr_i;
    logic [31:0] rs_data_o, rt_data_o, wb_data_o;
    logic        wb_en_o;
    logic [4:0]  wb_addr_o;

    wb_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .memdata_i  (memdata_i),
        .alures_i   (alures_i),
        .pc4_i      (pc4_i),
        .memtoreg_i (memtoreg_i),
        .regwr_i    (regwr_i),
        .rf_i       (rf_i),
        .rs_addr_i  (rs_addr_i),
        .rt_addr_i  (rt_addr_i),
        .rs_data_o  (rs_data_o),
        .rt_data_o  (rt_data_o),
        .wb_data_o  (wb_data_o),
        .wb_en_o    (wb_en_o),
        .wb_addr_o  (wb_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural register contents as a plain array.
    logic [31:0] m_regs [32];
    bit          m_valid;
    logic [31:0] m_wb;
    bit          m_en;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (m_en && a == rf_i) return m_wb;
`endif
        return m_regs[a];
    endfunction

    // Drive one cycle's inputs on the falling edge, then check every output.
    task automatic apply(input logic rst, input logic [1:0] m2r,
                         input logic [31:0] mem, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic we,
                         input logic [4:0] rf, input logic [4:0] rs,
                         input logic [4:0] rt);
        @(negedge clk);
        reset = rst; memtoreg_i = m2r; memdata_i = mem; alures_i = alu;
        pc4_i = pc4; regwr_i = we; rf_i = rf; rs_addr_i = rs; rt_addr_i = rt;
        #1;
        if (m2r == 2'b01)      m_wb = mem;
        else if (m2r == 2'b10) m_wb = pc4;
        else                   m_wb = alu;
        m_en = we && (rf != 5'd0);
        chk("wb_data", wb_data_o, m_wb);
        chk("wb_en", {31'b0, wb_en_o}, {31'b0, m_en});
        chk("wb_addr", {27'b0, wb_addr_o}, {27'b0, rf});
        if (m_valid) begin
            chk("rs_data", rs_data_o, exp_rd(rs));
            chk("rt_data", rt_data_o, exp_rd(rt));
        end
    endtask

    // Clock edge: update the model from the rules.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_regs[29] = 32'h0000_07FC;
            m_valid = 1'b1;
        end else if (m_en) begin
            m_regs[rf_i] = m_wb;
        end
    endtask

    logic [31:0] old9;

    initial begin
        m_valid = 1'b0; m_en = 1'b0; m_wb = '0;
        reset = 1'b0; memtoreg_i = '0; memdata_i = '0; alures_i = '0;
        pc4_i = '0; regwr_i = 1'b0; rf_i = '0; rs_addr_i = '0; rt_addr_i = '0;

        // Reset, then read $sp and $5.
        apply(1'b0, 2'b00, 0, 0, 0, 1'b0, 5'd0, 5'd29, 5'd5); tick();
        apply(1'b1, 2'b00, 0, 0, 0, 1'b0, 5'd0, 5'd29, 5'd5);
        chk("rst_sp", rs_data_o, 32'h0000_07FC);
        chk("rst_r5", rt_data_o, 32'h0);
        tick();

        // Writeback mux: Mem, PC+4, ALU(11).
        apply(1'b1, 2'b01, 32'hDEAD_BEEF, 32'h1111, 32'h2222, 1'b1, 5'd8, 5'd1, 5'd2); tick();
        apply(1'b1, 2'b10, 32'h3333, 32'h4444, 32'h0000_0104, 1'b1, 5'd31, 5'd8, 5'd8);
        chk("mux_mem", rs_data_o, 32'hDEAD_BEEF);
        tick();
        apply(1'b1, 2'b11, 32'h5555, 32'h5, 32'h6666, 1'b1, 5'd10, 5'd31, 5'd8);
        chk("mux_pc4", rs_data_o, 32'h0000_0104);
        chk("mux_alu_wb", wb_data_o, 32'h5);
        tick();
        apply(1'b1, 2'b00, 0, 0, 0, 1'b0, 5'd0, 5'd10, 5'd31);
        chk("mux_alu", rs_data_o, 32'h5);
        tick();

        // $0 is never written and always reads zero.
        apply(1'b1, 2'b00, 0, 32'hFFFF_FFFF, 0, 1'b1, 5'd0, 5'd0, 5'd0);
        chk("zero_en", {31'b0, wb_en_o}, 32'h0);
        chk("zero_rd", rs_data_o, 32'h0);
        tick();
        apply(1'b1, 2'b00, 0, 0, 0, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("zero_rd_next", rt_data_o, 32'h0);
        tick();

        // Same-cycle write/read of $9.
        old9 = m_regs[9];
        apply(1'b1, 2'b00, 0, 32'h1234, 0, 1'b1, 5'd9, 5'd9, 5'd1);
`ifdef WB_BYPASS_EN
        chk("bypass_now", rs_data_o, 32'h1234);
`else
        chk("bypass_now", rs_data_o, old9);
`endif
        tick();
        apply(1'b1, 2'b00, 0, 0, 0, 1'b0, 5'd0, 5'd9, 5'd9);
        chk("bypass_next", rs_data_o, 32'h1234);
        tick();

        // Reset beats a simultaneous write.
        apply(1'b1, 2'b00, 0, 32'h55, 0, 1'b1, 5'd3, 5'd0, 5'd0); tick();
        apply(1'b0, 2'b00, 0, 32'h7, 0, 1'b1, 5'd3, 5'd3, 5'd0); tick();
        apply(1'b1, 2'b00, 0, 0, 0, 1'b0, 5'd0, 5'd3, 5'd29);
        chk("rst_collide", rs_data_o, 32'h0);
        chk("rst_collide_sp", rt_data_o, 32'h0000_07FC);
        tick();

        // Back-to-back writes to $4, both ports reading $4.
        apply(1'b1, 2'b00, 0, 32'h1, 0, 1'b1, 5'd4, 5'd4, 5'd4); tick();
        apply(1'b1, 2'b00, 0, 32'h2, 0, 1'b1, 5'd4, 5'd4, 5'd4);
`ifndef WB_BYPASS_EN
        chk("b2b_first", rs_data_o, 32'h1);
`endif
        tick();
        apply(1'b1, 2'b00, 0, 0, 0, 1'b0, 5'd0, 5'd4, 5'd4);
        chk("b2b_second_rs", rs_data_o, 32'h2);
        chk("b2b_second_rt", rt_data_o, 32'h2);
        tick();

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            logic [4:0] rf, rs, rt;
            rf = 5'($urandom_range(0, 31));
            rs = ($urandom_range(0, 3) == 0) ? rf : 5'($urandom_range(0, 31));
            rt = ($urandom_range(0, 3) == 0) ? rf : 5'($urandom_range(0, 31));
            apply(($urandom_range(0, 49) != 0), 2'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  rf, rs, rt);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage plus architectural register file for the 5-stage MIPS pipeline.
- Consumes the MEM/WB pipeline register outputs and selects the writeback value.
- Commits that value to a 32x32 register file and serves the ID stage's two read ports.
- Exports the in-flight writeback value and destination for the forwarding unit.

Parameters:
- DATA_W, 32, datapath width.
- NREG, 32, register count; address width is clog2(NREG) = 5.
- SP_RST, 32'h0000_07FC, reset value of $29 ($sp).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- memdata_i  in  32  load data from MEM/WB.
- alures_i  in  32  ALU result from MEM/WB.
- pc4_i  in  32  PC+4 of the WB instruction (jal/jalr link).
- memtoreg_i  in  2  writeback select: 00 ALU, 01 Mem, 10 PC+4, 11 ALU.
- regwr_i  in  1  writeback enable.
- rf_i  in  5  destination register.
- rs_addr_i  in  5  read port 1 address.
- rt_addr_i  in  5  read port 2 address.
- rs_data_o  out  32  read port 1 data.
- rt_data_o  out  32  read port 2 data.
- wb_data_o  out  32  selected writeback value (combinational).
- wb_en_o  out  1  regwr_i AND rf_i != 0 (combinational).
- wb_addr_o  out  5  equals rf_i.

Behaviour:
- Writeback mux, combinational:
  - wb_data_o = memdata_i if memtoreg_i = 01.
  - wb_data_o = pc4_i if memtoreg_i = 10.
  - wb_data_o = alures_i otherwise (00 and 11).
- Write:
  - On rising clk with reset = 1 and wb_en_o = 1, reg[rf_i] <= wb_data_o.
  - One write per cycle.
- $0:
  - Never written; regwr_i with rf_i = 0 is a no-op.
  - Reads of address 0 always return 0, including under bypass.
- Reset:
  - On rising clk with reset = 0, all registers are cleared to 0, except reg[29] <= SP_RST.
  - Reset has priority over a simultaneous write.
  - A write asserted in the reset cycle is dropped.
  - Reset is synchronous; there is no asynchronous clear.
- Reads:
  - Combinational from the array, address to data, zero cycles.
  - The read data outputs have no reset flop; they reflect array contents after reset (all 0 except $sp).
- Write/read same cycle, same address:
  - Governed by WB_BYPASS_EN; see Optional Feature.
- Latency: a value presented at WB in cycle N is architecturally visible from cycle N+1 in all builds.
- Both read ports may address the same register; each returns identical data.
- wb_en_o, wb_addr_o and wb_data_o are purely combinational from the inputs, so forwarding sees the WB value in the same cycle.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - If wb_en_o = 1 and rs_addr_i = rf_i != 0, then rs_data_o = wb_data_o in that same cycle.
  - Same rule for rt_addr_i and rt_data_o.
  - This removes the WB-to-ID hazard.
- Undefined:
  - Read ports return stored contents only.
  - The hazard unit must then stall or forward one extra cycle.

Decomposition:
- Shared package pipe_pkg:
  - MEMTOREG_ALU = 2'b00, MEMTOREG_MEM = 2'b01, MEMTOREG_PC4 = 2'b10.
  - REG_ZERO = 5'd0, REG_SP = 5'd29, REG_RA = 5'd31.
  - Typedefs reg_addr_t (5-bit) and word_t (32-bit).
- One sub-module, regfile_core:
  - Contains the storage array, synchronous reset and write port, and the two combinational read ports with the zero-register rule.
  - The top instantiates it and adds the writeback mux, wb_en_o gating and the bypass.

Test Plan:
- Reset: hold reset = 0 one clk, then read $29 and $5 → rs_data_o = 32'h0000_07FC, rt_data_o = 0.
- Mux: memtoreg_i = 01, memdata_i = 32'hDEAD_BEEF, regwr_i = 1, rf_i = 8; next cycle read rs = 8 → 32'hDEAD_BEEF.
  - Repeat with memtoreg_i = 10, pc4_i = 32'h0000_0104, rf_i = 31 → $31 = 32'h0000_0104.
  - Repeat with memtoreg_i = 11, alures_i = 32'h5 → written value 32'h5.
- $0: regwr_i = 1, rf_i = 0, alures_i = 32'hFFFF_FFFF → wb_en_o = 0.
  - $0 reads 0 in that cycle and the next, including with WB_BYPASS_EN defined.
- Bypass: write $9 = 32'h1234 while rs_addr_i = 9 in the same cycle.
  - WB_BYPASS_EN defined → rs_data_o = 32'h1234 immediately.
  - Undefined → old value in that cycle, 32'h1234 next cycle.
- Reset collision: reset = 0 with regwr_i = 1, rf_i = 3, alures_i = 7 → after the clock, $3 = 0.
- Back-to-back writes: write $4 = 1, then $4 = 2 on consecutive cycles → reads show 1, then 2; rt port on $4 matches the rs port.
